regfile_read_sched: RTL and testbench

REGFILE_READ_SCHED -- requirements
Module: regfile_read_sched

---
 rtl/regfile_read_sched_pkg.sv | 17 +
 rtl/regfile_port_fsm.sv | 113 +++++++++++
 rtl/regfile_read_sched.sv | 158 +++++++++++++++
 tb/tb_regfile_read_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_sched_pkg.sv
// Shared types and default constants for the register-file read scheduler.
// Holds the per-port state enum and the default parameter values.
package regfile_read_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } port_state_e;

    localparam int DEF_NPORTS     = 2;
    localparam int DEF_XLEN       = 32;
    localparam int DEF_NREGS      = 32;
    localparam int DEF_RD_LATENCY = 3;

endpackage

// File: rtl/regfile_port_fsm.sv
// One read port of the scheduler: request/hold/drain state machine plus
// the held read-data register.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   valid         - port read request
//   addr_zero     - requested address is register 0
//   rel           - instruction release (clears the port)
//   grant         - arbiter granted this port's storage read this cycle
//   resp_valid    - pipeline response for this port arrives this cycle
//   resp_data     - data of that response
//   wr_hit        - write to the held address (forwarding builds only)
//   wr_data       - write data
//   req           - port asks the arbiter for a storage read
//   ready         - data held and valid
//   busy          - port in WAIT or DRAIN
//   rdata         - held read data
module regfile_port_fsm
    import regfile_read_sched_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic            addr_zero,
    input  logic            rel,
    input  logic            grant,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    input  logic            wr_hit,
    input  logic [XLEN-1:0] wr_data,
    output logic            req,
    output logic            ready,
    output logic            busy,
    output logic [XLEN-1:0] rdata
);

    port_state_e state;
    port_state_e state_nx;

    logic cap_resp;
    logic cap_zero;
    logic hold_upd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A grant with zero latency delivers its response in the grant cycle,
    // so IDLE can move straight to HOLD.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rel) begin
                    state_nx = IDLE;
                end else if (valid && addr_zero) begin
                    state_nx = HOLD;
                end else if (grant) begin
                    state_nx = resp_valid ? HOLD : WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    state_nx = rel ? IDLE : HOLD;
                end else if (rel) begin
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (rel) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (resp_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A releasing port never requests: a grant would leave an
    // orphaned response behind.
    always_comb begin
        req   = (state == IDLE) && valid && !addr_zero && !rel;
        ready = (state == HOLD);
        busy  = (state == WAIT) || (state == DRAIN);
    end

    assign cap_resp = resp_valid && !rel &&
                      ((state == WAIT) || ((state == IDLE) && grant));
    assign cap_zero = (state == IDLE) && valid && addr_zero && !rel;
    assign hold_upd = (state == HOLD) && !rel && wr_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (cap_resp) begin
            rdata <= resp_data;
        end else if (cap_zero) begin
            rdata <= '0;
        end else if (hold_upd) begin
            rdata <= wr_data;
        end
    end

endmodule

// File: rtl/regfile_read_sched.sv
// Register file with NPORTS scheduled read ports sharing one storage read
// per cycle through a fixed-priority arbiter and an RD_LATENCY pipeline.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes into the
// granted read and into ports holding the written address.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   rs_valid    - per-port read request
//   rs_addr     - packed per-port addresses, port 0 in LSBs
//   rs_ready    - per-port data held and valid
//   rs_rdata    - packed per-port read data, port 0 in LSBs
//   rs_release  - instruction complete, clears all ports
//   rd_we       - register write enable
//   rd_addr     - write address
//   rd_wdata    - write data
//   busy        - any port waiting on or draining a storage read
module regfile_read_sched
    import regfile_read_sched_pkg::*;
#(
    parameter int NPORTS     = DEF_NPORTS,
    parameter int XLEN       = DEF_XLEN,
    parameter int NREGS      = DEF_NREGS,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    localparam int AW        = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      rs_valid,
    input  logic [NPORTS*AW-1:0]   rs_addr,
    output logic [NPORTS-1:0]      rs_ready,
    output logic [NPORTS*XLEN-1:0] rs_rdata,
    input  logic                   rs_release,
    input  logic                   rd_we,
    input  logic [AW-1:0]          rd_addr,
    input  logic [XLEN-1:0]        rd_wdata,
    output logic                   busy
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [XLEN-1:0] regs [NREGS];

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] grant;
    logic [NPORTS-1:0] port_busy;
    logic              gnt_any;
    logic [PW-1:0]     gnt_idx;
    logic [AW-1:0]     gnt_addr;
    logic [XLEN-1:0]   s0_data;

    logic              resp_v;
    logic [PW-1:0]     resp_port;
    logic [XLEN-1:0]   resp_data;

    // Storage is not reset; register 0 is never written.
    always_ff @(posedge clk) begin
        if (rd_we && (rd_addr != '0)) begin
            regs[rd_addr] <= rd_wdata;
        end
    end

    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (req[i] && !gnt_any) begin
                grant[i] = 1'b1;
                gnt_any  = 1'b1;
                gnt_idx  = PW'(i);
            end
        end
    end

    assign gnt_addr = rs_addr[gnt_idx*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    assign s0_data = (rd_we && (rd_addr == gnt_addr)) ?
                     rd_wdata : regs[gnt_addr];
`else
    assign s0_data = regs[gnt_addr];
`endif

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign resp_v    = gnt_any;
            assign resp_port = gnt_idx;
            assign resp_data = s0_data;
        end else begin : g_pipe
            logic            pv [RD_LATENCY];
            logic [PW-1:0]   pp [RD_LATENCY];
            logic [XLEN-1:0] pd [RD_LATENCY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < RD_LATENCY; k++) begin
                        pv[k] <= 1'b0;
                        pp[k] <= '0;
                        pd[k] <= '0;
                    end
                end else begin
                    pv[0] <= gnt_any;
                    pp[0] <= gnt_idx;
                    pd[0] <= s0_data;
                    for (int k = 1; k < RD_LATENCY; k++) begin
                        pv[k] <= pv[k-1];
                        pp[k] <= pp[k-1];
                        pd[k] <= pd[k-1];
                    end
                end
            end

            assign resp_v    = pv[RD_LATENCY-1];
            assign resp_port = pp[RD_LATENCY-1];
            assign resp_data = pd[RD_LATENCY-1];
        end
    endgenerate

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_port
            logic [AW-1:0]   p_addr;
            logic [XLEN-1:0] p_rdata;
            logic            p_wr_hit;

            assign p_addr = rs_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
            assign p_wr_hit = rd_we && (rd_addr == p_addr) &&
                              (rd_addr != '0);
`else
            assign p_wr_hit = 1'b0;
`endif

            regfile_port_fsm #(
                .XLEN(XLEN)
            ) u_port (
                .clk        (clk),
                .reset      (reset),
                .valid      (rs_valid[i]),
                .addr_zero  (p_addr == '0),
                .rel        (rs_release),
                .grant      (grant[i]),
                .resp_valid (resp_v && (resp_port == PW'(i))),
                .resp_data  (resp_data),
                .wr_hit     (p_wr_hit),
                .wr_data    (rd_wdata),
                .req        (req[i]),
                .ready      (rs_ready[i]),
                .busy       (port_busy[i]),
                .rdata      (p_rdata)
            );

            assign rs_rdata[i*XLEN +: XLEN] = p_rdata;
        end
    endgenerate

    assign busy = |port_busy;

endmodule

// File: tb/tb_regfile_read_sched.sv
// Directed self-checking bench for regfile_read_sched
// (NPORTS=2, XLEN=32, NREGS=32, RD_LATENCY=3).
module tb_regfile_read_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rs_valid;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_ready;
    logic [63:0] rs_rdata;
    logic        rs_release;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    regfile_read_sched #(
        .NPORTS(2),
        .XLEN(32),
        .NREGS(32),
        .RD_LATENCY(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_valid   (rs_valid),
        .rs_addr    (rs_addr),
        .rs_ready   (rs_ready),
        .rs_rdata   (rs_rdata),
        .rs_release (rs_release),
        .rd_we      (rd_we),
        .rd_addr    (rd_addr),
        .rd_wdata   (rd_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        rd_we = 1'b1;
        rd_addr = a;
        rd_wdata = d;
        tick();
        rd_we = 1'b0;
    endtask

    task automatic do_release();
        rs_valid = 2'b00;
        rs_release = 1'b1;
        tick();
        rs_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rs_valid = 2'b00;
        rs_addr = '0;
        rs_release = 1'b0;
        rd_we = 1'b0;
        rd_addr = '0;
        rd_wdata = '0;
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b00) begin
            nerr++;
            $display("FAIL reset_ready: got %b want 00", rs_ready);
        end
        nvec++;
        if (rs_rdata !== 64'h0) begin
            nerr++;
            $display("FAIL reset_rdata: got %h want 0", rs_rdata);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rs_valid = 2'b01;
        rs_addr = {5'd0, 5'd5};
        tick();
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b00 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL single_wait: ready %b busy %b want 00 1",
                     rs_ready, busy);
        end
        tick();
        nvec++;
        if (rs_ready !== 2'b01) begin
            nerr++;
            $display("FAIL single_ready: got %b want 01", rs_ready);
        end
        nvec++;
        if (rs_rdata[31:0] !== 32'h1234) begin
            nerr++;
            $display("FAIL single_data: got %h want 1234", rs_rdata[31:0]);
        end
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b01 || rs_rdata[31:0] !== 32'h1234) begin
            nerr++;
            $display("FAIL single_hold: ready %b data %h want 01 1234",
                     rs_ready, rs_rdata[31:0]);
        end
        do_release();
        nvec++;
        if (rs_ready !== 2'b00) begin
            nerr++;
            $display("FAIL single_release: got %b want 00", rs_ready);
        end
    endtask

    task automatic test_both();
        rs_valid = 2'b11;
        rs_addr = {5'd6, 5'd5};
        for (int i = 0; i < 4; i++) tick();
        nvec++;
        if (rs_ready !== 2'b01 || rs_rdata[31:0] !== 32'h1234) begin
            nerr++;
            $display("FAIL both_p0: ready %b data %h want 01 1234",
                     rs_ready, rs_rdata[31:0]);
        end
        tick();
        nvec++;
        if (rs_ready !== 2'b11 || rs_rdata[63:32] !== 32'h5678) begin
            nerr++;
            $display("FAIL both_p1: ready %b data %h want 11 5678",
                     rs_ready, rs_rdata[63:32]);
        end
        do_release();
    endtask

    task automatic test_zero();
        rs_valid = 2'b11;
        rs_addr = {5'd0, 5'd5};
        tick();
        nvec++;
        if (rs_ready !== 2'b10 || rs_rdata[63:32] !== 32'h0) begin
            nerr++;
            $display("FAIL zero_p1: ready %b data %h want 10 0",
                     rs_ready, rs_rdata[63:32]);
        end
        tick();
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b11 || rs_rdata[31:0] !== 32'h1234) begin
            nerr++;
            $display("FAIL zero_p0: ready %b data %h want 11 1234",
                     rs_ready, rs_rdata[31:0]);
        end
        do_release();
    endtask

    task automatic test_drain();
        rs_valid = 2'b01;
        rs_addr = {5'd0, 5'd5};
        tick();
        rd_we = 1'b1;
        rd_addr = 5'd5;
        rd_wdata = 32'h2222;
        tick();
        rd_we = 1'b0;
        rs_valid = 2'b00;
        rs_release = 1'b1;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL drain_busy_t2: got %b want 1", busy);
        end
        tick();
        rs_release = 1'b0;
        nvec++;
        if (busy !== 1'b1 || rs_ready !== 2'b00) begin
            nerr++;
            $display("FAIL drain_t3: busy %b ready %b want 1 00",
                     busy, rs_ready);
        end
        tick();
        nvec++;
        if (busy !== 1'b0 || rs_ready !== 2'b00) begin
            nerr++;
            $display("FAIL drain_t4: busy %b ready %b want 0 00",
                     busy, rs_ready);
        end
        rs_valid = 2'b01;
        tick();
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b00) begin
            nerr++;
            $display("FAIL drain_no_pulse: got %b want 00", rs_ready);
        end
        tick();
        nvec++;
        if (rs_ready !== 2'b01 || rs_rdata[31:0] !== 32'h2222) begin
            nerr++;
            $display("FAIL drain_fresh: ready %b data %h want 01 2222",
                     rs_ready, rs_rdata[31:0]);
        end
        do_release();
    endtask

    task automatic test_grant_write();
        logic [31:0] exp_grant;
        logic [31:0] exp_hold;
`ifdef REGFILE_BYPASS_EN
        exp_grant = 32'hBEEF;
        exp_hold = 32'hCAFE;
`else
        exp_grant = 32'h1234;
        exp_hold = 32'h1234;
`endif
        do_write(5'd5, 32'h1234);
        rs_valid = 2'b01;
        rs_addr = {5'd0, 5'd5};
        rd_we = 1'b1;
        rd_addr = 5'd5;
        rd_wdata = 32'hBEEF;
        tick();
        rd_we = 1'b0;
        tick();
        tick();
        tick();
        nvec++;
        if (rs_ready !== 2'b01 || rs_rdata[31:0] !== exp_grant) begin
            nerr++;
            $display("FAIL grant_write: ready %b data %h want 01 %h",
                     rs_ready, rs_rdata[31:0], exp_grant);
        end
        do_write(5'd5, 32'hCAFE);
        nvec++;
        if (rs_ready !== 2'b01 || rs_rdata[31:0] !== exp_hold) begin
            nerr++;
            $display("FAIL hold_write: ready %b data %h want 01 %h",
                     rs_ready, rs_rdata[31:0], exp_hold);
        end
        do_release();
    endtask

    task automatic test_back_to_back();
        rs_valid = 2'b01;
        rs_addr = {5'd0, 5'd6};
        tick();
        tick();
        tick();
        rs_valid = 2'b00;
        rs_release = 1'b1;
        tick();
        rs_release = 1'b0;
        nvec++;
        if (rs_ready !== 2'b00 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL rel_on_resp: ready %b busy %b want 00 0",
                     rs_ready, busy);
        end
        rs_valid = 2'b10;
        rs_addr = {5'd6, 5'd0};
        for (int i = 0; i < 4; i++) tick();
        nvec++;
        if (rs_ready !== 2'b10 || rs_rdata[63:32] !== 32'h5678) begin
            nerr++;
            $display("FAIL b2b_p1: ready %b data %h want 10 5678",
                     rs_ready, rs_rdata[63:32]);
        end
        do_release();
    endtask

    task automatic test_async_reset();
        rs_valid = 2'b01;
        rs_addr = {5'd0, 5'd5};
        tick();
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL areset_pre: busy %b want 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || rs_ready !== 2'b00 || rs_rdata !== 64'h0) begin
            nerr++;
            $display("FAIL areset_now: busy %b ready %b data %h want 0",
                     busy, rs_ready, rs_rdata);
        end
        rs_valid = 2'b00;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (rs_ready !== 2'b00 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL areset_stale: cyc %0d ready %b busy %b",
                         i, rs_ready, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        do_write(5'd5, 32'h1234);
        do_write(5'd6, 32'h5678);
        do_write(5'd0, 32'hFFFF);
        test_single();
        test_both();
        test_zero();
        test_drain();
        test_back_to_back();
        test_grant_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
